// File: rtl/matrix_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// matrix_pkg : shared widths and register-master state encoding
// Rev 1.0
//------------------------------------------------------------------------------
package matrix_pkg;

   localparam int DATA_W   = 256;
   localparam int MAX_REGS = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      READ    = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } reg_master_state_t;

endpackage
`default_nettype wire

// File: rtl/register_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// register_master : valid/ready initiator driving the shared register-file bus
// Rev 1.0
//------------------------------------------------------------------------------
module register_master
   import matrix_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                Clock,
   input  logic                nReset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic [NUM_REGS-1:0] Enable,
   output logic                ReadWrite,
   output logic [DATA_W-1:0]   DataIn,
   input  logic [DATA_W-1:0]   DataOut
);

   localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

   reg_master_state_t   r_state;
   reg_master_state_t   w_state_nxt;
   logic [NUM_REGS-1:0] r_enable;
   logic [NUM_REGS-1:0] w_enable_nxt;
   logic                r_rw;
   logic                w_rw_nxt;
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic                r_rsp_err;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic [DATA_W-1:0]   r_datain;
   logic                w_in_range;

   function automatic logic [NUM_REGS-1:0] f_onehot(input logic [ADDR_W-1:0] a);
      f_onehot = NUM_REGS'(1) << a;
   endfunction

   assign w_in_range = ({1'b0, req_addr} < c_num_regs);

   // Bus values are computed for the next state so every bus output is a flop.
   always_comb begin
      w_state_nxt  = r_state;
      w_enable_nxt = '0;
      w_rw_nxt     = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (!w_in_range) begin
                  w_state_nxt = RESP;
               end else if (req_write) begin
                  w_state_nxt  = WRITE;
                  w_enable_nxt = f_onehot(req_addr);
               end else begin
                  w_state_nxt  = READ;
                  w_enable_nxt = f_onehot(req_addr);
                  w_rw_nxt     = 1'b1;
               end
            end
         end
         WRITE:   w_state_nxt = RESP;
         READ:    w_state_nxt = CAPTURE;
         CAPTURE: w_state_nxt = RESP;
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state     <= IDLE;
         r_enable    <= '0;
         r_rw        <= 1'b0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_enable    <= w_enable_nxt;
         r_rw        <= w_rw_nxt;
         r_req_ready <= (w_state_nxt == IDLE);
         r_rsp_valid <= (w_state_nxt == RESP);
      end
   end

   // The target releases DataOut at the edge ending CAPTURE, so sample exactly there.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_datain    <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         if ((r_state == IDLE) && (w_state_nxt == WRITE)) begin
            r_datain <= req_wdata;
         end
         if ((r_state == IDLE) && req_valid) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= !w_in_range;
         end
         if (r_state == CAPTURE) begin
            r_rsp_rdata <= DataOut;
         end
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign Enable    = r_enable;
   assign ReadWrite = r_rw;
   assign DataIn    = r_datain;

endmodule
`default_nettype wire

// File: doc/register_master.md
# register_master

Bus initiator for the matrix engine's 256-bit register file. It accepts read and write requests from the engine's datapath through a valid/ready handshake. It drives the shared `Enable`/`ReadWrite`/`DataIn` bus toward `NUM_REGS` single-register targets and captures the shared tri-stated `DataOut` bus. It returns one response per accepted request. One 256-bit word holds one 4x4 matrix of 16-bit elements.

## Interface
- `NUM_REGS`, default 4: number of register targets; one `Enable` line each; legal range 2..16.
- `ADDR_W`, default `$clog2(NUM_REGS)`: request address width; derived, do not override.
- `Clock` in, 1: sole clock; all state updates on the rising edge.
- `nReset` in, 1: asynchronous, active-low reset.
- `req_valid` in, 1: request present.
- `req_ready` out, 1: master can accept a request.
- `req_write` in, 1: 1 = write, 0 = read.
- `req_addr` in, `ADDR_W`: target register index.
- `req_wdata` in, 256: write data.
- `rsp_valid` out, 1: response present.
- `rsp_ready` in, 1: consumer accepts the response.
- `rsp_rdata` out, 256: read data; 0 for write and error responses.
- `rsp_err` out, 1: address out of range; no bus access was made.
- `Enable` out, `NUM_REGS`: one-hot target select; all-zero when idle.
- `ReadWrite` out, 1: 1 = read, 0 = write.
- `DataIn` out, 256: write data bus to targets.
- `DataOut` in, 256: shared read bus from targets; high-Z when no target is enabled.

## Operation
- FSM states:
  - `IDLE`: `req_ready` = 1.
    - On `req_valid` at a rising edge, latch `write`, `addr` and `wdata`.
    - `addr >= NUM_REGS` → `RESP` with `rsp_err` = 1.
    - Otherwise a write → `WRITE`; a read → `READ`.
  - `WRITE` (1 cycle): `Enable[addr]` = 1, `ReadWrite` = 0, `DataIn` = latched `wdata`; → `RESP`.
  - `READ` (1 cycle): `Enable[addr]` = 1, `ReadWrite` = 1. The target loads `DataOut` at the end of this cycle. → `CAPTURE`.
  - `CAPTURE` (1 cycle): `Enable` = 0. `DataOut` still holds the target's data during this cycle.
    - Sample `DataOut` into `rsp_rdata` at the edge that ends `CAPTURE`. The target floats the bus at that same edge, so capture must not be later.
    - → `RESP`.
  - `RESP`: `rsp_valid` = 1 and all response fields held stable until `rsp_ready`; then → `IDLE`.
- `req_ready` is 0 in every state other than `IDLE`. At most one transaction is in flight.
- All bus outputs are registered and decoded from state plus latched fields; no combinational path from request inputs to the bus.
- `DataIn` keeps its last value outside `WRITE`. `ReadWrite` returns to 0 outside `READ`.
- Only one `Enable` bit is ever high, and never for more than one cycle per transaction.
- Address compare is unsigned over the full `ADDR_W`. Non-power-of-two `NUM_REGS` yields error indices.
- The write response carries `rsp_rdata` = 0 and `rsp_err` = 0. The error response carries `rsp_rdata` = 0.

## Timing
- Reset values: `req_ready` 1 (in `IDLE`), `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `Enable` 0, `ReadWrite` 0, `DataIn` 0.
- All latencies are counted from the request-accept edge E0.
  - Write: bus active in cycle E0→E1; `rsp_valid` high after E1.
  - Read: bus active in cycle E0→E1; capture at E2; `rsp_valid` high after E2.
  - Error: `rsp_valid` high after E0; zero bus activity.
- Response stall: remaining in `RESP` for any number of cycles causes no bus activity.
- Back-to-back: `rsp_ready` at edge En returns to `IDLE`. The next request is accepted at En+1 at the earliest, so full throughput is 1 op per 3 cycles (write) or 4 cycles (read).
- Reset asserted mid-transaction: immediate return to `IDLE`, `Enable` forced to 0 asynchronously, and the in-flight op is dropped with no response. A write interrupted in `WRITE` may or may not have landed in the target.
- `req_valid` held while busy has no effect until `IDLE`.

## Structure
- Shared package `matrix_pkg`:
  - `DATA_W` = 256.
  - `MAX_REGS` = 16.
  - `reg_master_state_t` enum: `IDLE`, `WRITE`, `READ`, `CAPTURE`, `RESP`.
- No sub-module. The one-hot enable decode is an inline function of the latched address.

## Test plan
- Write 0xA5 repeated to address 2 with `NUM_REGS` = 4 → `Enable` = 4'b0100 and `ReadWrite` = 0 for exactly one cycle; `rsp_valid` after E1 with `rsp_err` 0.
- Read address 2 after that write → `Enable` = 4'b0100 and `ReadWrite` = 1 for one cycle; `rsp_rdata` = 0xA5 repeated, `rsp_valid` after E2.
- Read address 5 with `NUM_REGS` = 5 → `rsp_err` 1, `rsp_rdata` 0, `Enable` never nonzero.
- Hold `rsp_ready` = 0 for 10 cycles on a read → `rsp_rdata` stable, `req_ready` 0, `Enable` stays 0 throughout.
- Assert `nReset` low during `READ` → `Enable` 0 within the same cycle, no response; the next read of the same address returns correct data.
- 100 random back-to-back reads and writes against 4 register models → every read matches the last write to that address, and `Enable` is never multi-hot.
